branch_predictor: RTL



---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_if.sv | 22 ++
 rtl/branch_predictor.sv | 84 ++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared counter helpers for the branch predictor: saturating counter step
// and the reset/allocate counter values, all generic in the counter width.
package bp_pkg;

  localparam int CTR_MAXW = 16;

  localparam int DEF_CTR_BITS = 2;

  function automatic logic [CTR_MAXW-1:0] ctr_reset_val(input int bits);
    return CTR_MAXW'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAXW-1:0] ctr_alloc_val(input int bits);
    return CTR_MAXW'(1 << (bits - 1));
  endfunction

  localparam logic [CTR_MAXW-1:0] DEF_CTR_RESET = ctr_reset_val(DEF_CTR_BITS);
  localparam logic [CTR_MAXW-1:0] DEF_CTR_ALLOC = ctr_alloc_val(DEF_CTR_BITS);

  // Saturates at 0 and 2^bits-1; never wraps in either direction.
  function automatic logic [CTR_MAXW-1:0] ctr_next(input logic [CTR_MAXW-1:0] ctr,
                                                   input logic taken,
                                                   input int bits);
    logic [CTR_MAXW-1:0] max_v;
    max_v = CTR_MAXW'((1 << bits) - 1);
    if (taken) begin
      return (ctr >= max_v) ? max_v : ctr + CTR_MAXW'(1);
    end
    return (ctr == '0) ? '0 : ctr - CTR_MAXW'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and Execute training signals between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PC_F;
  logic             predict_taken_F;
  logic [WIDTH-1:0] predict_target_F;
  logic             update_en_E;
  logic [WIDTH-1:0] update_PC_E;
  logic             update_taken_E;
  logic [WIDTH-1:0] update_target_E;

  modport master (
    output PC_F, update_en_E, update_PC_E, update_taken_E, update_target_E,
    input  predict_taken_F, predict_target_F
  );

  modport slave (
    input  PC_F, update_en_E, update_PC_E, update_taken_E, update_target_E,
    output predict_taken_F, predict_target_F
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: combinational lookup
// from Fetch, single-port training from Execute, no write-to-read bypass.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDX - 2;

  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(ctr_reset_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_alloc_val(CTR_BITS));

  logic                r_valid  [ENTRIES];
  logic [TAGW-1:0]     r_tag    [ENTRIES];
  logic [WIDTH-1:0]    r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

  logic [IDX-1:0]      w_idx_f;
  logic [TAGW-1:0]     w_tag_f;
  logic                w_hit_f;
  logic [IDX-1:0]      w_idx_e;
  logic [TAGW-1:0]     w_tag_e;
  logic                w_hit_e;
  logic [CTR_BITS-1:0] w_ctr_trained;
  logic [3:0]          w_unused_pc_bits;

  // Instructions are word aligned, so the byte offset carries no information.
  assign w_unused_pc_bits = {bp.PC_F[1:0], bp.update_PC_E[1:0]};

  assign w_idx_f = bp.PC_F[IDX+1:2];
  assign w_tag_f = bp.PC_F[WIDTH-1:IDX+2];
  assign w_idx_e = bp.update_PC_E[IDX+1:2];
  assign w_tag_e = bp.update_PC_E[WIDTH-1:IDX+2];

  always_comb begin
    w_hit_f             = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    bp.predict_taken_F  = w_hit_f && r_ctr[w_idx_f][CTR_BITS-1];
    bp.predict_target_F = w_hit_f ? r_target[w_idx_f] : '0;
  end

  always_comb begin
    w_hit_e       = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    w_ctr_trained = CTR_BITS'(ctr_next(CTR_MAXW'(r_ctr[w_idx_e]), bp.update_taken_E, CTR_BITS));
  end

  // Each entry owns its registers; only the entry selected by the EX index is written.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic w_sel;
      assign w_sel = bp.update_en_E && (w_idx_e == IDX'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid[gi]  <= 1'b0;
          r_tag[gi]    <= '0;
          r_target[gi] <= '0;
          r_ctr[gi]    <= CTR_RST;
        end else if (w_sel) begin
          if (w_hit_e) begin
            r_ctr[gi] <= w_ctr_trained;
            if (bp.update_taken_E) begin
              r_target[gi] <= bp.update_target_E;
            end
          end else if (bp.update_taken_E) begin
            // A not-taken miss leaves the resident entry alone.
            r_valid[gi]  <= 1'b1;
            r_tag[gi]    <= w_tag_e;
            r_target[gi] <= bp.update_target_E;
            r_ctr[gi]    <= CTR_ALLOC;
          end
        end
      end
    end
  endgenerate

endmodule
